// File: rtl/up_counter.sv
// ----------------------------------------------------------------------------
// up_counter
//
// Free-running binary up-counter with wrap-around. It reports when the count
// reaches its terminal value and when it wraps, and keeps a saturating count
// of wraps. Typical uses are an LED heartbeat or a tick source for other
// blocks. There is no enable: the block counts on every rising clock edge
// while it is out of reset.
//
// Parameters:
//   WIDTH      - counter width in bits
//   MAX_VAL    - terminal value; the count wraps MAX_VAL -> 0 (legal 1..2**WIDTH-1)
//   WRAP_CNT_W - width of the saturating wrap counter
//
// Ports:
//   clk      in   1           system clock, rising edge
//   rst_n    in   1           asynchronous active-low reset
//   out      out  WIDTH       current count, registered
//   tc       out  1           terminal count, decoded from out (out == MAX_VAL)
//   wrap     out  1           registered one-cycle pulse after a MAX_VAL -> 0 step
//   wrap_cnt out  WRAP_CNT_W  wraps since reset, saturates at all-ones
//   gray     out  WIDTH       registered Gray code of out (UP_COUNTER_GRAY_EN only)
//
// Build option:
//   UP_COUNTER_GRAY_EN - when defined, adds the gray output and its register.
// ----------------------------------------------------------------------------
module up_counter #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned MAX_VAL    = 2**WIDTH - 1,
   parameter int unsigned WRAP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [WIDTH-1:0]      out,
   output logic                  tc,
   output logic                  wrap,
   output logic [WRAP_CNT_W-1:0] wrap_cnt
`ifdef UP_COUNTER_GRAY_EN
   ,
   output logic [WIDTH-1:0]      gray
`endif
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0]      r_out;
   logic                  r_wrap;
   logic [WRAP_CNT_W-1:0] r_wrap_cnt;

   logic                  w_at_max;
   logic [WIDTH-1:0]      w_next;
   logic                  w_cnt_sat;

   always_comb begin
      w_at_max  = (r_out == MaxVal);
      w_next    = w_at_max ? '0 : r_out + WIDTH'(1);
      w_cnt_sat = &r_wrap_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out      <= '0;
         r_wrap     <= 1'b0;
         r_wrap_cnt <= '0;
      end else begin
         r_out  <= w_next;
         // High for exactly the cycle following the MAX_VAL -> 0 step.
         r_wrap <= w_at_max;
         if (w_at_max && !w_cnt_sat) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_CNT_W'(1);
         end
      end
   end

`ifdef UP_COUNTER_GRAY_EN
   logic [WIDTH-1:0] r_gray;

   // Encoded from the next count so gray changes on the same edge as out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gray <= '0;
      end else begin
         r_gray <= w_next ^ (w_next >> 1);
      end
   end

   assign gray = r_gray;
`endif

   assign out      = r_out;
   assign tc       = (r_out == MaxVal);
   assign wrap     = r_wrap;
   assign wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_up_counter.sv
module tb_up_counter;

   localparam int unsigned WIDTH      = 4;
   localparam int unsigned MAX_VAL    = 15;
   localparam int unsigned WRAP_CNT_W = 8;
   localparam int unsigned SAT_VAL    = 255;

   logic                  clk;
   logic                  rst_n;
   logic [WIDTH-1:0]      out;
   logic                  tc;
   logic                  wrap;
   logic [WRAP_CNT_W-1:0] wrap_cnt;
`ifdef UP_COUNTER_GRAY_EN
   logic [WIDTH-1:0]      gray;
   logic [WIDTH-1:0]      prev_gray;
`endif

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int unsigned cnt;
      int unsigned tcv;
      int unsigned wrp;
      int unsigned wc;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state
   int unsigned m_out;
   int unsigned m_wrap;
   int unsigned m_wc;

   up_counter #(
      .WIDTH      (WIDTH),
      .MAX_VAL    (MAX_VAL),
      .WRAP_CNT_W (WRAP_CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .out      (out),
      .tc       (tc),
      .wrap     (wrap),
      .wrap_cnt (wrap_cnt)
`ifdef UP_COUNTER_GRAY_EN
      ,
      .gray     (gray)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out  = 0;
      m_wrap = 0;
      m_wc   = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_out"}, out, 0);
      check_val({tag, "_tc"}, tc, 0);
      check_val({tag, "_wrap"}, wrap, 0);
      check_val({tag, "_wcnt"}, wrap_cnt, 0);
`ifdef UP_COUNTER_GRAY_EN
      check_val({tag, "_gray"}, gray, 0);
`endif
   endtask

   // One clock edge: advance the model, push its prediction, then compare DUT output.
   task automatic step();
      exp_t e;
      exp_t g;
      @(posedge clk);
      if (m_out == MAX_VAL) begin
         m_out  = 0;
         m_wrap = 1;
         if (m_wc < SAT_VAL) m_wc++;
      end else begin
         m_out++;
         m_wrap = 0;
      end
      e.cnt = m_out;
      e.tcv = (m_out == MAX_VAL) ? 1 : 0;
      e.wrp = m_wrap;
      e.wc  = m_wc;
      exp_q.push_back(e);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      end else begin
         g = exp_q.pop_front();
         check_val("out", out, g.cnt);
         check_val("tc", tc, g.tcv);
         check_val("wrap", wrap, g.wrp);
         check_val("wrap_cnt", wrap_cnt, g.wc);
`ifdef UP_COUNTER_GRAY_EN
         check_val("gray", gray, g.cnt ^ (g.cnt >> 1));
         check_val("gray_1bit", $countones(gray ^ prev_gray), 1);
         prev_gray = gray;
`endif
      end
   endtask

   initial begin
      rst_n = 1'b0;
      model_reset();
`ifdef UP_COUNTER_GRAY_EN
      prev_gray = '0;
`endif
      #1;
      check_reset_state("rst_t1");
      @(posedge clk);
      #1;
      check_reset_state("rst_clk");
      #14;
      rst_n = 1'b1;  // t = 20 ns

      // Count through one wrap: edges 25..215 ns
      for (int i = 0; i < 20; i++) step();
      #4;  // t = 220 ns
      check_val("out_at_220", out, 4);
      check_val("wcnt_at_220", wrap_cnt, 1);

      // Asynchronous reset between edges
      rst_n = 1'b0;
      #1;
      check_reset_state("mid_rst");
      model_reset();
`ifdef UP_COUNTER_GRAY_EN
      prev_gray = '0;
`endif
      #19;
      rst_n = 1'b1;  // t = 240 ns
      for (int i = 0; i < 5; i++) step();
      #4;  // t = 290 ns
      check_val("out_at_290", out, 5);

      // Saturation of the wrap counter
      for (int i = 0; i < 256 * 16; i++) step();
      check_val("wcnt_sat", wrap_cnt, SAT_VAL);
      for (int i = 0; i < 40; i++) step();
      check_val("wcnt_hold", wrap_cnt, SAT_VAL);

      check_val("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
